mem_bank_responder: RTL

- Single-clock, dual-port ECC memory bank: the responder end of the controller's memory-side interface.
- Accepts the enable, write-enable, address and 12-bit Hamming codeword signals on ports A and B.
- Stores codewords and returns them with programmable per-port write and read latency. The controller's decoders consume the read data.
- Flags same-address write collisions.

---
 rtl/mem_bank_responder_if.sv | 59 +++++
 rtl/mem_bank_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_responder_if.sv
// -----------------------------------------------------------------------------
// mem_bank_responder_if
// Memory-side bus between the ECC controller (master) and the dual-port bank
// (slave). Groups the per-port request signals and the read-response signals.
//
// Signals (A and B ports are symmetric):
//   I_en*        request enable
//   I_we*        1 = write, 0 = read (only meaningful with I_en*)
//   I_Add*       address, A_W bits
//   I_Din*       write codeword, R_W bits
//   O_Dout*      read codeword, R_W bits
//   O_valid*     one-cycle pulse qualifying O_Dout*
//   O_collision  one-cycle pulse after a same-address A/B write commit
//
// Build option ERR_INJECT_EN adds I_inj* / I_err_mask* for read-data error
// injection.
// -----------------------------------------------------------------------------
interface mem_bank_responder_if #(
    parameter int A_W = 4,
    parameter int R_W = 12
);
    logic           I_enA;
    logic           I_weA;
    logic [A_W-1:0] I_AddA;
    logic [R_W-1:0] I_DinA;
    logic           I_enB;
    logic           I_weB;
    logic [A_W-1:0] I_AddB;
    logic [R_W-1:0] I_DinB;
    logic [R_W-1:0] O_DoutA;
    logic [R_W-1:0] O_DoutB;
    logic           O_validA;
    logic           O_validB;
    logic           O_collision;
`ifdef ERR_INJECT_EN
    logic           I_injA;
    logic           I_injB;
    logic [R_W-1:0] I_err_maskA;
    logic [R_W-1:0] I_err_maskB;
`endif

    modport master (
        output I_enA, I_weA, I_AddA, I_DinA,
        output I_enB, I_weB, I_AddB, I_DinB,
`ifdef ERR_INJECT_EN
        output I_injA, I_injB, I_err_maskA, I_err_maskB,
`endif
        input  O_DoutA, O_DoutB, O_validA, O_validB, O_collision
    );

    modport slave (
        input  I_enA, I_weA, I_AddA, I_DinA,
        input  I_enB, I_weB, I_AddB, I_DinB,
`ifdef ERR_INJECT_EN
        input  I_injA, I_injB, I_err_maskA, I_err_maskB,
`endif
        output O_DoutA, O_DoutB, O_validA, O_validB, O_collision
    );
endinterface

// File: rtl/mem_bank_responder.sv
// -----------------------------------------------------------------------------
// mem_bank_responder
// Dual-port ECC memory bank: responder end of the controller's memory bus.
// Stores 12-bit Hamming codewords and returns them with per-port programmable
// write latency (WL_*) and read latency (RL_*), each 1..8.
//
// Ports:
//   I_clk    single rising-edge clock for both ports
//   I_rst_n  asynchronous active-low reset (pipelines and outputs cleared,
//            array contents kept)
//   bus      mem_bank_responder_if.slave (requests in, read data/valid and
//            collision pulse out)
//
// Timing: a request is accepted on the edge where I_en*=1. A write commits to
// the array WL edges later. A read samples the array on the acceptance edge
// (read-before-write, no forwarding from pending writes) and the word is
// presented RL cycles after acceptance for one cycle; O_Dout* holds otherwise.
// Same-edge A/B commits to one address: A wins, O_collision pulses next cycle.
//
// Build option: define ERR_INJECT_EN to add I_inj*/I_err_mask* on the bus.
// The mask of an injecting read rides with the request and is XORed into the
// returned word at the output; the array is never touched.
// -----------------------------------------------------------------------------

// Per-port write and read pipelines. The array itself lives in the top so the
// two ports' commits can be arbitrated in one place.
module mem_bank_port_pipe #(
    parameter int A_W = 4,
    parameter int R_W = 12,
    parameter int WL  = 1,
    parameter int RL  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           we,
    input  logic [A_W-1:0] addr,
    input  logic [R_W-1:0] din,
    input  logic [R_W-1:0] rd_word,    // array word at addr, pre-edge value
    input  logic [R_W-1:0] rd_mask,    // error-injection mask, 0 when unused
    output logic           wr_commit,
    output logic [A_W-1:0] wr_addr,
    output logic [R_W-1:0] wr_data,
    output logic [R_W-1:0] dout,
    output logic           valid
);
    if (WL < 1 || WL > 8) begin : g_bad_wl
        $error("mem_bank_port_pipe: WL=%0d outside 1..8", WL);
    end
    if (RL < 1 || RL > 8) begin : g_bad_rl
        $error("mem_bank_port_pipe: RL=%0d outside 1..8", RL);
    end

    logic [WL-1:0]          wr_vld_pipe_q, wr_vld_pipe_d;
    logic [WL-1:0][A_W-1:0] wr_addr_q, wr_addr_d;
    logic [WL-1:0][R_W-1:0] wr_data_q, wr_data_d;

    logic [RL-1:0]          rd_vld_pipe_q, rd_vld_pipe_d;
    logic [RL-1:0][R_W-1:0] rd_word_q, rd_word_d;
    logic [RL-1:0][R_W-1:0] rd_mask_q, rd_mask_d;

    logic acc_wr, acc_rd;
    assign acc_wr = en & we;
    assign acc_rd = en & ~we;

    always_comb begin
        wr_vld_pipe_d    = wr_vld_pipe_q;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        wr_vld_pipe_d[0] = acc_wr;
        wr_addr_d[0]     = addr;
        wr_data_d[0]     = din;
        for (int i = 1; i < WL; i++) begin
            wr_vld_pipe_d[i] = wr_vld_pipe_q[i-1];
            wr_addr_d[i]     = wr_addr_q[i-1];
            wr_data_d[i]     = wr_data_q[i-1];
        end
    end

    // Read stages only load on a valid token so the last stage (and thus
    // dout) holds its previous word between responses.
    always_comb begin
        rd_vld_pipe_d    = rd_vld_pipe_q;
        rd_word_d        = rd_word_q;
        rd_mask_d        = rd_mask_q;
        rd_vld_pipe_d[0] = acc_rd;
        if (acc_rd) begin
            rd_word_d[0] = rd_word;
            rd_mask_d[0] = rd_mask;
        end
        for (int i = 1; i < RL; i++) begin
            rd_vld_pipe_d[i] = rd_vld_pipe_q[i-1];
            if (rd_vld_pipe_q[i-1]) begin
                rd_word_d[i] = rd_word_q[i-1];
                rd_mask_d[i] = rd_mask_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_pipe_q <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_vld_pipe_q <= '0;
            rd_word_q     <= '0;
            rd_mask_q     <= '0;
        end else begin
            wr_vld_pipe_q <= wr_vld_pipe_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_vld_pipe_q <= rd_vld_pipe_d;
            rd_word_q     <= rd_word_d;
            rd_mask_q     <= rd_mask_d;
        end
    end

    assign wr_commit = wr_vld_pipe_q[WL-1];
    assign wr_addr   = wr_addr_q[WL-1];
    assign wr_data   = wr_data_q[WL-1];
    assign valid     = rd_vld_pipe_q[RL-1];
    // Injection is applied at the output; both terms reset to 0 and hold
    // together, so dout is 0 in reset and stable between responses.
    assign dout      = rd_word_q[RL-1] ^ rd_mask_q[RL-1];
endmodule

module mem_bank_responder #(
    parameter int A_W  = 4,
    parameter int R_W  = 12,
    parameter int WL_A = 1,
    parameter int RL_A = 2,
    parameter int WL_B = 1,
    parameter int RL_B = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    mem_bank_responder_if.slave  bus
);
    localparam int DEPTH = 2**A_W;

    // Array is intentionally not reset; contents are undefined until written.
    logic [R_W-1:0] mem_array [DEPTH];

    logic [R_W-1:0] mask_a, mask_b;
`ifdef ERR_INJECT_EN
    assign mask_a = bus.I_injA ? bus.I_err_maskA : '0;
    assign mask_b = bus.I_injB ? bus.I_err_maskB : '0;
`else
    assign mask_a = '0;
    assign mask_b = '0;
`endif

    logic           wa_commit, wb_commit;
    logic [A_W-1:0] wa_addr, wb_addr;
    logic [R_W-1:0] wa_data, wb_data;

    mem_bank_port_pipe #(.A_W(A_W), .R_W(R_W), .WL(WL_A), .RL(RL_A)) u_port_a (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .en        (bus.I_enA),
        .we        (bus.I_weA),
        .addr      (bus.I_AddA),
        .din       (bus.I_DinA),
        .rd_word   (mem_array[bus.I_AddA]),
        .rd_mask   (mask_a),
        .wr_commit (wa_commit),
        .wr_addr   (wa_addr),
        .wr_data   (wa_data),
        .dout      (bus.O_DoutA),
        .valid     (bus.O_validA)
    );

    mem_bank_port_pipe #(.A_W(A_W), .R_W(R_W), .WL(WL_B), .RL(RL_B)) u_port_b (
        .clk       (I_clk),
        .rst_n     (I_rst_n),
        .en        (bus.I_enB),
        .we        (bus.I_weB),
        .addr      (bus.I_AddB),
        .din       (bus.I_DinB),
        .rd_word   (mem_array[bus.I_AddB]),
        .rd_mask   (mask_b),
        .wr_commit (wb_commit),
        .wr_addr   (wb_addr),
        .wr_data   (wb_data),
        .dout      (bus.O_DoutB),
        .valid     (bus.O_validB)
    );

    // B is written first so A's nonblocking update wins on an address tie.
    always_ff @(posedge I_clk) begin
        if (wb_commit) mem_array[wb_addr] <= wb_data;
        if (wa_commit) mem_array[wa_addr] <= wa_data;
    end

    logic collision_d, collision_q;
    assign collision_d = wa_commit & wb_commit & (wa_addr == wb_addr);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) collision_q <= 1'b0;
        else          collision_q <= collision_d;
    end

    assign bus.O_collision = collision_q;
endmodule
